collision_detector: RTL
=======================

// Module: collision_detector
// PURPOSE
//  Downstream consumer of the obstacle position/size outputs and the player sprite box.
//  Performs an axis-aligned bounding-box overlap test, then runs a hit/invulnerability/lives FSM.
//  Drives the obstacle controller's collision input (one game tick wide), and a lives count and
//  game_over flag for the top-level/renderer. All state advances only on game_en ticks.
// PARAMETERS
//  LIVES_INIT      4'd3    lives loaded at reset/restart (legal 1..15)
//  COOLDOWN_TICKS  8'd60   game_en ticks of invulnerability after a hit (legal >=1)
//  HIT_MARGIN      10'd2   pixels trimmed from every side of the player box (forgiving hitbox)
//  FLASH_PERIOD    8'd4    game_en ticks per hit_flash half-period (HIT_FLASH_EN only)
// PORTS
//  clk              in   1   50 MHz system clock
//  rst              in   1   asynchronous, active-low reset
//  game_en          in   1   one-clk tick enable from the game clock generator
//  restart          in   1   synchronous active-high; reload lives, return to ARMED
//  player_x/_y      in   10  player top-left pixel
//  player_w/_h      in   10  player size
//  obstacle_x/_y    in   10  obstacle top-left pixel (x may be 640 = off-screen right)
//  obstacle_w/_h    in   10  obstacle size
//  collision        out  1   to obstacle controller; high for exactly one game_en interval
//  lives            out  4   lives remaining
//  game_over        out  1   sticky until restart
//  hit_flash        out  1   renderer blink during cooldown
// BEHAVIOUR
//  Reset: collision=0, lives=LIVES_INIT, game_over=0, hit_flash=0, state=ARMED, cnt=0, ovl_q=0.
//  Overlap: all sums in 11 bits (no wrap). Player box = [px+M, px+pw-M) x [py+M, py+ph-M), M=HIT_MARGIN.
//   If pw<=2M or ph<=2M: no overlap. Hit iff pxl<ox+ow && ox<pxr && pyt<oy+oh && oy<pyb (strict; touching edges=miss).
//   Zero-width/height obstacle never overlaps. ovl_q registered every clk (1 clk latency), ungated by game_en.
//  FSM (transitions only on clk with game_en=1, unless noted):
//   ARMED:     ovl_q=1 -> collision<=1, lives<=lives-1 (saturate at 0), -> HIT. Else stay.
//   HIT:       collision<=0; lives==0 -> GAME_OVER (game_over<=1); else cnt<=COOLDOWN_TICKS, -> COOLDOWN.
//   COOLDOWN:  overlap ignored; cnt<=cnt-1; cnt==1 -> ARMED (exactly COOLDOWN_TICKS ticks).
//   GAME_OVER: all outputs frozen, overlap ignored; exits only via restart.
//  collision therefore rises one clk after the detecting tick and falls on the next tick, so the
//   obstacle controller samples it exactly once.
//  restart: any state, any game_en value; priority over game_en -> ARMED, lives=LIVES_INIT,
//   collision=0, game_over=0, hit_flash=0, cnt=0. ovl_q unaffected.
//  rst asserted mid-hit/cooldown: immediate return to reset values (async).
//  Illegal state encoding: -> ARMED on next clk.
// CONFIGURATION
//  HIT_FLASH_EN defined: in COOLDOWN, hit_flash toggles every FLASH_PERIOD game_en ticks, starting
//   high on COOLDOWN entry; forced 0 on leaving COOLDOWN.
//  HIT_FLASH_EN undefined: hit_flash tied 0; flash counter and FLASH_PERIOD logic not built.
// STRUCTURE
//  collision_pkg: state encoding (ARMED/HIT/COOLDOWN/GAME_OVER, 2 bits), COORD_W=10,
//   LIVES_W=4, SCREEN_W=640 constants.
//  Sub-module aabb_overlap: combinational 11-bit box test (margin + strict compare);
//   parent registers its output into ovl_q.
// TESTING
//  1 Reset, player (100,285,30x30), obstacle (640,285,30x30), 100 ticks -> collision never high, lives=3.
//  2 Obstacle to x=125 -> collision high for one game_en interval, lives 3->2, then 60 ticks no hit despite overlap.
//  3 Edge: obstacle x=128 (player right edge 128 after margin) -> no hit; x=127 -> hit.
//  4 Three hits spaced by cooldown -> lives=0, game_over=1 after HIT; further overlap no change; restart -> lives=3, ARMED.
//  5 rst low during COOLDOWN and restart coincident with game_en+overlap -> reset values, no collision pulse.
//  6 HIT_FLASH_EN build: FLASH_PERIOD=4 -> hit_flash 1,1,1,1,0,0,0,0... over cooldown ticks, 0 after exit; undefined build -> always 0.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and constants for the player/obstacle collision logic.
// No logic here; state encoding, coordinate widths and box-edge struct only.
// Backpressure: not applicable.
package collision_pkg;
    localparam int SCREEN_W = 640;
    localparam int COORD_W  = $clog2(SCREEN_W);
    localparam int SUM_W    = COORD_W + 1;
    localparam int LIVES_W  = 4;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        HIT       = 2'd1,
        COOLDOWN  = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    // Box edges in widened coordinates so sums never wrap.
    typedef struct packed {
        logic [SUM_W-1:0] l;
        logic [SUM_W-1:0] r;
        logic [SUM_W-1:0] t;
        logic [SUM_W-1:0] b;
    } edges_t;
endpackage

// File: rtl/collision_detector_aabb_overlap.sv
// Purpose: axis-aligned overlap of the margin-trimmed player box and the obstacle box.
// Latency: purely combinational; the parent registers the result.
// Backpressure: none, evaluated continuously.
module aabb_overlap
    import collision_pkg::*;
#(
    parameter logic [COORD_W-1:0] MARGIN = 10'd2
) (
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    input  logic [COORD_W-1:0] player_w,
    input  logic [COORD_W-1:0] player_h,
    input  logic [COORD_W-1:0] obstacle_x,
    input  logic [COORD_W-1:0] obstacle_y,
    input  logic [COORD_W-1:0] obstacle_w,
    input  logic [COORD_W-1:0] obstacle_h,
    output logic               overlap
);
    edges_t           pb;
    edges_t           ob;
    logic [SUM_W-1:0] m2;
    logic             p_ok;
    logic             o_ok;

    always_comb begin
        m2   = {MARGIN, 1'b0};
        pb.l = {1'b0, player_x} + {1'b0, MARGIN};
        pb.r = {1'b0, player_x} + {1'b0, player_w} - {1'b0, MARGIN};
        pb.t = {1'b0, player_y} + {1'b0, MARGIN};
        pb.b = {1'b0, player_y} + {1'b0, player_h} - {1'b0, MARGIN};
        ob.l = {1'b0, obstacle_x};
        ob.r = {1'b0, obstacle_x} + {1'b0, obstacle_w};
        ob.t = {1'b0, obstacle_y};
        ob.b = {1'b0, obstacle_y} + {1'b0, obstacle_h};
        // A player no wider than twice the margin has an empty hitbox.
        p_ok = ({1'b0, player_w} > m2) && ({1'b0, player_h} > m2);
        o_ok = (obstacle_w != '0) && (obstacle_h != '0);
        overlap = p_ok && o_ok &&
                  (pb.l < ob.r) && (ob.l < pb.r) &&
                  (pb.t < ob.b) && (ob.t < pb.b);
    end
endmodule

// File: rtl/collision_detector.sv
// Purpose: box hit test plus hit/cooldown/lives FSM; optional hit_flash blink under HIT_FLASH_EN.
// Latency: overlap registered 1 clk; collision rises 1 clk after the detecting game_en tick.
// Backpressure: none; state only advances on game_en ticks, restart takes priority.
module collision_detector
    import collision_pkg::*;
#(
    parameter logic [LIVES_W-1:0] LIVES_INIT     = 4'd3,
    parameter logic [7:0]         COOLDOWN_TICKS = 8'd60,
    parameter logic [COORD_W-1:0] HIT_MARGIN     = 10'd2
`ifdef HIT_FLASH_EN
    ,
    parameter logic [7:0]         FLASH_PERIOD   = 8'd4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic               restart,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    input  logic [COORD_W-1:0] player_w,
    input  logic [COORD_W-1:0] player_h,
    input  logic [COORD_W-1:0] obstacle_x,
    input  logic [COORD_W-1:0] obstacle_y,
    input  logic [COORD_W-1:0] obstacle_w,
    input  logic [COORD_W-1:0] obstacle_h,
    output logic               collision,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic               hit_flash
);
    logic               ovl;
    logic               ovl_q;
    state_t             state;
    state_t             state_n;
    logic [7:0]         cnt;
    logic [7:0]         cnt_n;
    logic [LIVES_W-1:0] lives_n;
    logic               collision_n;
    logic               game_over_n;

    aabb_overlap #(.MARGIN(HIT_MARGIN)) u_aabb (
        .player_x   (player_x),
        .player_y   (player_y),
        .player_w   (player_w),
        .player_h   (player_h),
        .obstacle_x (obstacle_x),
        .obstacle_y (obstacle_y),
        .obstacle_w (obstacle_w),
        .obstacle_h (obstacle_h),
        .overlap    (ovl)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovl_q     <= 1'b0;
            state     <= ARMED;
            cnt       <= '0;
            lives     <= LIVES_INIT;
            collision <= 1'b0;
            game_over <= 1'b0;
        end else begin
            ovl_q     <= ovl;
            state     <= state_n;
            cnt       <= cnt_n;
            lives     <= lives_n;
            collision <= collision_n;
            game_over <= game_over_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lives_n     = lives;
        collision_n = collision;
        game_over_n = game_over;
        if (restart) begin
            state_n     = ARMED;
            cnt_n       = '0;
            lives_n     = LIVES_INIT;
            collision_n = 1'b0;
            game_over_n = 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (game_en && ovl_q) begin
                        collision_n = 1'b1;
                        lives_n     = (lives == '0) ? '0 : lives - 4'd1;
                        state_n     = HIT;
                    end
                end
                HIT: begin
                    if (game_en) begin
                        collision_n = 1'b0;
                        if (lives == '0) begin
                            game_over_n = 1'b1;
                            state_n     = GAME_OVER;
                        end else begin
                            cnt_n   = COOLDOWN_TICKS;
                            state_n = COOLDOWN;
                        end
                    end
                end
                COOLDOWN: begin
                    if (game_en) begin
                        cnt_n = cnt - 8'd1;
                        if (cnt == 8'd1) state_n = ARMED;
                    end
                end
                GAME_OVER: begin
                    state_n = GAME_OVER;
                end
                default: begin
                    state_n = ARMED;
                end
            endcase
        end
    end

`ifdef HIT_FLASH_EN
    logic [7:0] flash_cnt;

    // Blink starts high on cooldown entry and is cleared as cooldown ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_flash <= 1'b0;
            flash_cnt <= '0;
        end else if (restart) begin
            hit_flash <= 1'b0;
            flash_cnt <= '0;
        end else if (state != COOLDOWN && state_n == COOLDOWN) begin
            hit_flash <= 1'b1;
            flash_cnt <= '0;
        end else if (state == COOLDOWN && state_n != COOLDOWN) begin
            hit_flash <= 1'b0;
            flash_cnt <= '0;
        end else if (state == COOLDOWN && game_en) begin
            if (flash_cnt == FLASH_PERIOD - 8'd1) begin
                hit_flash <= ~hit_flash;
                flash_cnt <= '0;
            end else begin
                flash_cnt <= flash_cnt + 8'd1;
            end
        end
    end
`else
    assign hit_flash = 1'b0;
`endif
endmodule
